// File: rtl/pulse_hold_tx.sv
// pulse_hold_tx
//   Transmit-side event shaper for a single-wire link whose receiver uses a
//   majority deglitch filter. Each event strobe becomes a line pulse that is
//   high for exactly HOLD cycles and is followed by at least GAP low cycles.
//   Events that arrive while a pulse is in flight are counted and then
//   replayed in order. Events beyond the counter capacity are dropped and
//   recorded in a sticky overflow flag.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   event_in  in   event strobe, one event per high cycle
//   ovf_clr   in   clears the sticky overflow flag
//   line_out  out  shaped line level, driven straight from a flop
//   busy      out  pulse in flight or events still queued
//   pending   out  queued events not yet started
//   overflow  out  sticky: at least one event was dropped
module pulse_hold_tx #(
    parameter int unsigned HOLD  = 8,
    parameter int unsigned GAP   = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_in,
    input  logic             ovf_clr,
    output logic             line_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int unsigned TMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // The timer counts down to zero, so zero marks the last cycle of a phase.
    localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD - 1);
    localparam logic [TW-1:0]    GAP_LAST  = TW'(GAP - 1);
    localparam logic [TW-1:0]    TIMER_ONE = TW'(1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] pend_q,  pend_d;
    logic             ovf_q,   ovf_d;
    logic             line_q,  line_d;

    logic gap_done;
    logic start;
    logic drop;

    always_comb begin
        gap_done = (state_q == ST_LOW) && (timer_q == '0);
        start    = ((state_q == ST_IDLE) || gap_done) &&
                   ((pend_q != '0) || event_in);
        // A full counter can still take an event when a pulse starts in the
        // same cycle: one leaves the queue while the new one enters.
        drop     = event_in && !start && (pend_q == PEND_MAX);

        state_d = state_q;
        timer_d = timer_q;
        if (start) begin
            state_d = ST_HIGH;
            timer_d = HOLD_LAST;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    if (timer_q == '0) begin
                        state_d = ST_LOW;
                        timer_d = GAP_LAST;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                ST_LOW: begin
                    if (timer_q == '0) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        pend_d = pend_q;
        if (event_in && !start && !drop) begin
            pend_d = pend_q + PEND_ONE;
        end else if (!event_in && start) begin
            pend_d = pend_q - PEND_ONE;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d  = drop || (ovf_q && !ovf_clr);

        // Registering the next-state decode keeps line_out glitch-free.
        line_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            line_q  <= line_d;
        end
    end

    assign line_out = line_q;
    assign busy     = (state_q != ST_IDLE) || (pend_q != '0);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: doc/pulse_hold_tx.md
Name: pulse_hold_tx

Overview:
- Transmit-side shaper for single-wire event links whose far end runs an N-of-M majority deglitch filter.
- Each 1-cycle event strobe becomes a line pulse held high for exactly HOLD cycles, followed by at least GAP low cycles, so every level survives the receiver's filter window.
- Events arriving during a pulse are counted and replayed in order; excess events are dropped and flagged.
- Sits at the output pad boundary, in the same clock domain as the event source.

Parameters:
- HOLD, 8, high time of each line pulse in clk cycles; must be >= 1; set >= receiver M.
- GAP, 8, minimum low time between pulses in clk cycles; must be >= 1; set >= receiver M.
- CNT_W, 4, width of the pending-event counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- event_in  input  1  event strobe, one event per high cycle.
- ovf_clr  input  1  clears the sticky overflow flag.
- line_out  output  1  shaped line level; registered, glitch-free.
- busy  output  1  high while state != IDLE or pending != 0.
- pending  output  CNT_W  number of queued events not yet started.
- overflow  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (async assert): line_out=0, pending=0, overflow=0, state=IDLE, timer=0, busy=0. An in-flight pulse is truncated immediately.
- Reset release: normal operation from the next clk edge.
- States: IDLE, HIGH, LOW. Timer width is clog2(max(HOLD,GAP)+1).
- start = (state==IDLE, or state==LOW with timer on its final GAP cycle) and (pending!=0 or event_in).
- On start:
  - Next state is HIGH; line_out=1 from the next cycle.
  - Latency from event_in in IDLE with pending==0 is 1 cycle.
- HIGH: line_out=1 for exactly HOLD cycles, then LOW.
- LOW: line_out=0 for exactly GAP cycles. On the last GAP cycle:
  - if start is true, go to HIGH (back-to-back pulses, line period HOLD+GAP);
  - otherwise go to IDLE.
- event_in during HIGH or LOW never alters the current pulse timing.
- pending_next = pending + event_in - start. An event consumed directly by start in the same cycle never appears in pending.
- Saturation: if pending == 2^CNT_W-1, event_in=1 and start=0, the event is dropped, pending holds, and overflow is set.
- If saturated and start=1 in the same cycle, the event is accepted and pending is unchanged.
- Overflow clear: overflow is cleared by ovf_clr. If a drop occurs in the same cycle as ovf_clr, set wins.
- busy is combinational from registered state and pending. It drops in the first IDLE cycle with pending==0.
- line_out is driven directly from a flop, with no combinational path from inputs.

Test Plan:
Parameters for all scenarios: HOLD=4, GAP=3, CNT_W=2.
1. Single event: event_in high at cycle 10 only -> line_out=1 cycles 11-14, 0 from cycle 15; state IDLE and busy=0 at cycle 18; pending stays 0; overflow stays 0.
2. Burst of 3: event_in high cycles 10,11,12 -> pending 1 at 12, 2 at 13; pulses high 11-14, 18-21, 25-28; pending decrements at 17 and 24; busy=0 at 32.
3. Overflow: event_in high cycles 10-15 (6 events) -> first starts directly; pending reaches 3 at cycle 14; events at 14 and 15 dropped; overflow=1 from cycle 15; exactly 4 pulses emitted.
4. Saturated accept: pending=3, event_in coincides with the LOW-final-cycle start -> pending stays 3, overflow stays 0.
5. Overflow clear race: overflow=1, ovf_clr=1 with no drop -> overflow=0 next cycle. ovf_clr=1 with a simultaneous drop -> overflow stays 1.
6. Reset mid-pulse: assert reset asynchronously at cycle 12 of scenario 2 -> line_out=0, pending=0, busy=0 before the next clk edge. After release, a single event reproduces scenario 1 timing.
